// File: rtl/ps2_voice_allocator.sv
// PS/2 scan-code sequencer: tracks make/break/extended prefixes and assigns held
// note keys to NUM_VOICES voice slots, stealing round-robin when all are busy.
module ps2_voice_allocator #(
  parameter int unsigned NUM_VOICES     = 4,
  parameter int unsigned DEFAULT_OCTAVE = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [7:0]              received_data,
  input  logic                    received_data_en,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [2:0]              octave,
  output logic                    note_event,
  output logic [2:0]              event_voice,
  output logic                    event_on
);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

  state_t          state, state_nx;
  logic            do_make, do_break;
  logic            is_note, oct_down, oct_up;
  logic [3:0]      key_id;
  logic [3:0]      key_r  [NUM_VOICES];
  logic [6:0]      note_r [NUM_VOICES];
  logic [2:0]      steal_ptr, steal_nx;
  logic            match_found, free_found;
  logic [2:0]      match_idx, free_idx, alloc_idx;
  logic [NUM_VOICES-1:0] match_vec;
  logic [6:0]      new_note;

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (received_data_en) begin
      unique case (state)
        S_IDLE:      if (received_data == 8'hF0)      state_nx = S_BREAK;
                     else if (received_data == 8'hE0) state_nx = S_EXT;
        S_BREAK:     state_nx = S_IDLE;
        S_EXT:       state_nx = (received_data == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        S_EXT_BREAK: state_nx = S_IDLE;
        default:     state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    do_make  = received_data_en && (state == S_IDLE) &&
               (received_data != 8'hF0) && (received_data != 8'hE0);
    do_break = received_data_en && (state == S_BREAK);
  end

  always_comb begin
    is_note  = 1'b1;
    key_id   = '0;
    oct_down = 1'b0;
    oct_up   = 1'b0;
    case (received_data)
      8'h1C: key_id = 4'd0;
      8'h1D: key_id = 4'd1;
      8'h1B: key_id = 4'd2;
      8'h23: key_id = 4'd3;
      8'h24: key_id = 4'd4;
      8'h2B: key_id = 4'd5;
      8'h2C: key_id = 4'd6;
      8'h34: key_id = 4'd7;
      8'h33: key_id = 4'd8;
      8'h3C: key_id = 4'd9;
      8'h3B: key_id = 4'd10;
      8'h35: key_id = 4'd11;
      8'h1A: begin is_note = 1'b0; oct_down = 1'b1; end
      8'h22: begin is_note = 1'b0; oct_up   = 1'b1; end
      default: is_note = 1'b0;
    endcase
  end

  // Same match vector serves typematic detection on make and release on break.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    match_vec   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (voice_gate[v] && key_r[v] == key_id) begin
        match_vec[v] = 1'b1;
        if (!match_found) begin
          match_found = 1'b1;
          match_idx   = 3'(v);
        end
      end
      if (!voice_gate[v] && !free_found) begin
        free_found = 1'b1;
        free_idx   = 3'(v);
      end
    end
    alloc_idx = free_found ? free_idx : steal_ptr;
    steal_nx  = (steal_ptr == 3'(NUM_VOICES - 1)) ? '0 : steal_ptr + 3'd1;
    new_note  = 7'(octave) * 7'd12 + 7'(key_id);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      voice_gate  <= '0;
      octave      <= 3'(DEFAULT_OCTAVE);
      steal_ptr   <= '0;
      note_event  <= 1'b0;
      event_voice <= '0;
      event_on    <= 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        key_r[v]  <= '0;
        note_r[v] <= '0;
      end
    end else begin
      note_event <= 1'b0;
      if (do_make && is_note && !match_found) begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (3'(v) == alloc_idx) begin
            voice_gate[v] <= 1'b1;
            key_r[v]      <= key_id;
            note_r[v]     <= new_note;
          end
        end
        if (!free_found) steal_ptr <= steal_nx;
        note_event  <= 1'b1;
        event_voice <= alloc_idx;
        event_on    <= 1'b1;
      end
      if (do_make && oct_down && octave != 3'd0) octave <= octave - 3'd1;
      if (do_make && oct_up   && octave != 3'd7) octave <= octave + 3'd1;
      if (do_break && is_note && match_found) begin
        voice_gate  <= voice_gate & ~match_vec;
        note_event  <= 1'b1;
        event_voice <= match_idx;
        event_on    <= 1'b0;
      end
    end
  end

  always_comb begin
    voice_note = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++)
      voice_note[7*v +: 7] = note_r[v];
  end

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Directed bench for ps2_voice_allocator (4 voices, default octave 4).
module tb_ps2_voice_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  received_data;
  logic        received_data_en;
  logic [3:0]  voice_gate;
  logic [27:0] voice_note;
  logic [2:0]  octave;
  logic        note_event;
  logic [2:0]  event_voice;
  logic        event_on;

  int checks   = 0;
  int failures = 0;

  ps2_voice_allocator #(.NUM_VOICES(4), .DEFAULT_OCTAVE(4)) dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .voice_gate       (voice_gate),
    .voice_note       (voice_note),
    .octave           (octave),
    .note_event       (note_event),
    .event_voice      (event_voice),
    .event_on         (event_on)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] note_of(input int v);
    return 32'(voice_note[7*v +: 7]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, when the byte's effect is visible.
  task automatic strobe(input logic [7:0] b);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clk);
    received_data_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    received_data = 8'h00;
    received_data_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gate", 32'(voice_gate), 0);
    check("rst_note", 32'(voice_note), 0);
    check("rst_octave", 32'(octave), 4);
    check("rst_event", 32'(note_event), 0);
    check("rst_ev_voice", 32'(event_voice), 0);
    check("rst_ev_on", 32'(event_on), 0);
    reset = 1'b0;
    @(negedge clk);

    strobe(8'h1C);
    check("on_gate", 32'(voice_gate), 4'b0001);
    check("on_note0", note_of(0), 48);
    check("on_event", 32'(note_event), 1);
    check("on_ev_on", 32'(event_on), 1);
    check("on_ev_voice", 32'(event_voice), 0);
    @(negedge clk);
    check("event_pulse_len", 32'(note_event), 0);
    strobe(8'hF0);
    check("f0_no_event", 32'(note_event), 0);
    strobe(8'h1C);
    check("off_gate", 32'(voice_gate), 0);
    check("off_event", 32'(note_event), 1);
    check("off_ev_on", 32'(event_on), 0);
    check("off_note_kept", note_of(0), 48);

    strobe(8'h1C);
    for (int i = 0; i < 3; i++) begin
      strobe(8'h1C);
      check("typematic_event", 32'(note_event), 0);
      check("typematic_gate", 32'(voice_gate), 4'b0001);
    end
    strobe(8'hF0); strobe(8'h1C);
    check("typematic_release", 32'(voice_gate), 0);

    strobe(8'h1C); strobe(8'h1D); strobe(8'h1B); strobe(8'h23);
    check("fill_gate", 32'(voice_gate), 4'b1111);
    check("fill_n0", note_of(0), 48);
    check("fill_n1", note_of(1), 49);
    check("fill_n2", note_of(2), 50);
    check("fill_n3", note_of(3), 51);
    strobe(8'h24);
    check("steal0_note", note_of(0), 52);
    check("steal0_voice", 32'(event_voice), 0);
    check("steal0_on", 32'(event_on), 1);
    strobe(8'h2B);
    check("steal1_note", note_of(1), 53);
    check("steal1_voice", 32'(event_voice), 1);
    strobe(8'hF0); strobe(8'h24);
    strobe(8'hF0); strobe(8'h2B);
    strobe(8'hF0); strobe(8'h1B);
    check("rel_ev_voice", 32'(event_voice), 2);
    check("rel_ev_on", 32'(event_on), 0);
    strobe(8'hF0); strobe(8'h23);
    check("rel_all_gate", 32'(voice_gate), 0);

    for (int i = 0; i < 4; i++) strobe(8'h22);
    check("oct_sat_hi", 32'(octave), 7);
    check("oct_no_event", 32'(note_event), 0);
    strobe(8'h35);
    check("note_max", note_of(0), 95);
    for (int i = 0; i < 8; i++) strobe(8'h1A);
    check("oct_sat_lo", 32'(octave), 0);
    check("oct_hold_note", note_of(0), 95);
    strobe(8'h1C);
    check("note_min", note_of(1), 0);
    check("note_min_voice", 32'(event_voice), 1);
    strobe(8'hF0); strobe(8'h35);
    strobe(8'hF0); strobe(8'h1C);
    check("rel2_gate", 32'(voice_gate), 0);

    strobe(8'hE0); strobe(8'h1C);
    check("ext_make_event", 32'(note_event), 0);
    check("ext_make_gate", 32'(voice_gate), 0);
    strobe(8'h15);
    check("unmapped_event", 32'(note_event), 0);
    strobe(8'h1C);
    check("plain_after_ext", 32'(voice_gate), 4'b0001);
    check("plain_after_ext_ev", 32'(note_event), 1);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h1C);
    check("ext_break_gate", 32'(voice_gate), 4'b0001);
    check("ext_break_event", 32'(note_event), 0);
    strobe(8'hF0); strobe(8'h1C);

    strobe(8'hF0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    strobe(8'h1C);
    check("post_rst_on", 32'(event_on), 1);
    check("post_rst_gate", 32'(voice_gate), 4'b0001);
    check("post_rst_note", note_of(0), 48);

    strobe(8'h1C);
    check("held_repeat_event", 32'(note_event), 0);
    strobe(8'h22);
    check("oct_up", 32'(octave), 5);
    strobe(8'hF0); strobe(8'h1C);
    check("rel_after_oct_gate", 32'(voice_gate), 0);
    check("rel_after_oct_note", note_of(0), 48);
    check("rel_after_oct_ev", 32'(event_on), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_voice_allocator.md
# ps2_voice_allocator

Sequences decoded PS/2 keyboard bytes into polyphonic note assignments for the synth. Sits between the PS/2 receive path (received_data / received_data_en) and the tone generators. Tracks make/break/extended prefixes, maps note keys to semitones, applies an octave register, and shares NUM_VOICES voice slots among held keys, stealing round-robin when all slots are busy.

## Interface
- NUM_VOICES, 4, number of voice slots (2..8)
- DEFAULT_OCTAVE, 4, octave register value after reset (0..7)

- CLOCK_50  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high
- received_data  input  8  byte from PS/2 receiver
- received_data_en  input  1  one-cycle strobe; received_data valid this cycle
- voice_gate  output  NUM_VOICES  bit v high while voice v is sounding
- voice_note  output  7*NUM_VOICES  note number of voice v in bits [7v+6:7v]
- octave  output  3  current octave register
- note_event  output  1  one-cycle pulse on any gate or note change
- event_voice  output  3  voice index of the last event
- event_on  output  1  1 = note-on/steal, 0 = note-off

## Operation
- Key map (scan code -> semitone key id): 1C->0, 1D->1, 1B->2, 23->3, 24->4, 2B->5, 2C->6, 34->7, 33->8, 3C->9, 3B->10, 35->11. Octave keys: 1A (Z) down, 22 (X) up. All other codes are unmapped.
- Prefix FSM, advances only on received_data_en:
  - IDLE: F0 -> BREAK; E0 -> EXT; else process as make, stay IDLE.
  - BREAK: any byte processed as break, then IDLE.
  - EXT: F0 -> EXT_BREAK; else discard, then IDLE.
  - EXT_BREAK: discard byte, then IDLE. Extended keys never affect voices.
- Per-voice state: gate, key id (4b), note (7b).
- Make of a note key:
  - If any gated voice already holds that key id: typematic repeat, no change, no event.
  - Else if a voice is free: allocate the lowest-index free voice.
  - Else steal voice steal_ptr, then steal_ptr <= (steal_ptr+1) mod NUM_VOICES.
  - Allocated voice gets gate=1, key id, note = octave*12 + key id (7 bits, max 95, no overflow). Pulses note_event with event_on=1.
- Break of a note key: every gated voice with a matching key id gets gate=0 (note field retained). Event reports the lowest matching index with event_on=0. No match: no event.
- Octave make: Z decrements, X increments, saturating at 0 and 7. Held voices are unchanged. Octave breaks are ignored. No note_event.
- Unmapped make or break: no state change except the FSM.

## Timing
- Reset values: voice_gate=0, all voice_note=0, octave=DEFAULT_OCTAVE, note_event=0, event_voice=0, event_on=0, FSM=IDLE, steal_ptr=0.
- Latency: a byte strobed in cycle N updates outputs in cycle N+1. note_event is high only in cycle N+1.
- Back-to-back strobes on consecutive cycles are fully supported: one byte is processed per cycle and none are dropped.
- Break compares key ids against state registered before the current cycle.
- A reset asserted mid-sequence (e.g. after F0) returns to IDLE. The next byte is treated as a make.
- Free-voice search and steal are resolved in the same cycle as the byte; there is no multi-cycle allocation.

## Test plan
- Reset, then strobe 1C -> cycle+1: voice_gate=0001, voice_note[6:0]=48, note_event=1, event_on=1, event_voice=0. Then F0,1C -> voice_gate=0000, event_on=0.
- 1C held, strobe 1C three more times (typematic) -> no note_event, voice_gate stays 0001.
- Makes 1C,1D,1B,23,24 with NUM_VOICES=4 -> voices 0..3 get 48,49,50,51; fifth make steals voice 0 (note 52), steal_ptr=1. Sixth new make 2B steals voice 1 (note 53).
- Strobe 22 four times -> octave saturates at 7. Strobe 35 -> note 95. Strobe 1A eight times -> octave 0. Strobe 1C -> note 0.
- Strobe E0,1C then E0,F0,1C -> no voice change, no events. A following plain 1C -> note-on. Strobe F0, assert reset, strobe 1C -> note-on (not break).
- Strobe 1C, 22, then F0,1C -> voice 0 released despite the octave change; the stored note stays 48.
